// File: rtl/interval_timer_arbiter_pkg.sv
// Shared types and width helper for the interval timer arbiter.
// The optional abort feature is enabled by defining TIMER_ARB_ABORT_EN.
package timer_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned OWNER_W(input int unsigned n);
    return (n > 2) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/interval_timer_arbiter_if.sv
// Requester-side bundle of the interval timer arbiter.
// The abort signal exists only when TIMER_ARB_ABORT_EN is defined.
interface interval_timer_arbiter_if
  import timer_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned OW = OWNER_W(NREQ);

  logic [NREQ-1:0]            req;
  logic [NREQ-1:0][WIDTH-1:0] duration;
  logic [NREQ-1:0]            ack;
  logic [NREQ-1:0]            done;
  logic                       busy;
  logic [WIDTH-1:0]           count;
  logic [OW-1:0]              owner;
`ifdef TIMER_ARB_ABORT_EN
  logic                       abort;

  modport master (output req, duration, abort, input ack, done, busy, count, owner);
  modport slave  (input req, duration, abort, output ack, done, busy, count, owner);
`else
  modport master (output req, duration, input ack, done, busy, count, owner);
  modport slave  (input req, duration, output ack, done, busy, count, owner);
`endif

endinterface

// File: rtl/interval_timer_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches req starting one past the
// last owner (or at 0 when nothing has been granted since reset).
module rr_arbiter
  import timer_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned OW  = OWNER_W(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   last,
  input  logic            has_last,
  output logic [NREQ-1:0] grant_oh,
  output logic [OW-1:0]   grant_idx
);

  int unsigned   base;
  logic [OW-1:0] idx;
  logic          found;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    base      = has_last ? ((32'(last) + 32'd1) % NREQ) : 32'd0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = OW'((base + i) % NREQ);
      if (!found && req[idx]) begin
        found          = 1'b1;
        grant_idx      = idx;
        grant_oh[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interval_timer_arbiter.sv
// Round-robin owner of one shared interval counter: grant, count 0..max, pulse done.
// Optional abort input when TIMER_ARB_ABORT_EN is defined.
module interval_timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input logic                   clock,
  input logic                   reset_n,
  interval_timer_arbiter_if.slave bus
);

  localparam int unsigned OW = OWNER_W(NREQ);

  timer_state_t      state_q, state_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  max_q, max_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic              has_last_q, has_last_d;

  logic [NREQ-1:0]   grant_oh;
  logic [OW-1:0]     grant_idx;
  logic              abort_req;

`ifdef TIMER_ARB_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req       (bus.req),
    .last      (owner_q),
    .has_last  (has_last_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d    = state_q;
    ack_d      = '0;
    done_d     = '0;
    count_d    = count_q;
    max_d      = max_q;
    owner_d    = owner_q;
    has_last_d = has_last_q;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (|bus.req) begin
          ack_d      = grant_oh;
          owner_d    = grant_idx;
          max_d      = bus.duration[grant_idx];
          has_last_d = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (abort_req) begin
          count_d = '0;
          state_d = IDLE;
        end else if (count_q == max_q) begin
          count_d = '0;
          done_d  = NREQ'(1) << owner_q;
          state_d = DONE;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ack_q      <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      count_q    <= '0;
      max_q      <= '0;
      owner_q    <= '0;
      has_last_q <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      count_q    <= count_d;
      max_q      <= max_d;
      owner_q    <= owner_d;
      has_last_q <= has_last_d;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.count = count_q;
  assign bus.owner = owner_q;

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Directed bench for interval_timer_arbiter (NREQ=4, WIDTH=8); the abort
// scenario is included when TIMER_ARB_ABORT_EN is defined.
module tb_interval_timer_arbiter;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  interval_timer_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

  interval_timer_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ack"},   32'(bus.ack),   32'h0);
    chk({tag, "_done"},  32'(bus.done),  32'h0);
    chk({tag, "_busy"},  32'(bus.busy),  32'h0);
    chk({tag, "_count"}, 32'(bus.count), 32'h0);
  endtask

  initial begin
    bit seen_done;
    bus.req      = '0;
    bus.duration = '0;
`ifdef TIMER_ARB_ABORT_EN
    bus.abort    = 1'b0;
`endif
    #12;
    chk_idle("reset");
    chk("reset_owner", 32'(bus.owner), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // Single request, duration 3: ack, count 0..3, done, 5 busy cycles.
    bus.req = 4'b0001;
    bus.duration[0] = 8'd3;
    step();
    chk("t1_ack",   32'(bus.ack),   32'h1);
    chk("t1_owner", 32'(bus.owner), 32'h0);
    chk("t1_busy0", 32'(bus.busy),  32'h1);
    chk("t1_cnt0",  32'(bus.count), 32'h0);
    bus.req = '0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("t1_cnt",  32'(bus.count), 32'(k));
      chk("t1_ackx", 32'(bus.ack),   32'h0);
      chk("t1_busy", 32'(bus.busy),  32'h1);
      chk("t1_dnx",  32'(bus.done),  32'h0);
    end
    step();
    chk("t1_done",  32'(bus.done),  32'h1);
    chk("t1_busyd", 32'(bus.busy),  32'h1);
    chk("t1_cntd",  32'(bus.count), 32'h0);
    step();
    chk_idle("t1_end");

    // Fresh reset, then all four requesting with duration 1: 0,1,2,3,0 every 4 cycles.
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) bus.duration[i] = 8'd1;
    for (int g = 0; g < 5; g++) begin
      step();
      chk("t2_ack",   32'(bus.ack),   32'(4'b0001 << (g % 4)));
      chk("t2_owner", 32'(bus.owner), 32'(g % 4));
      if (g == 4) bus.req = '0;
      step();
      chk("t2_cnt1",  32'(bus.count), 32'h1);
      step();
      chk("t2_done",  32'(bus.done),  32'(4'b0001 << (g % 4)));
      step();
      chk("t2_gap",   32'(bus.ack),   32'h0);
      chk("t2_idleb", 32'(bus.busy),  32'h0);
    end
    step();
    chk_idle("t2_end");

    // Duration 0 on requester 2: one RUN cycle at count 0, then done.
    bus.duration[2] = 8'd0;
    bus.req = 4'b0100;
    step();
    chk("t3_ack",   32'(bus.ack),   32'h4);
    chk("t3_owner", 32'(bus.owner), 32'h2);
    chk("t3_cnt",   32'(bus.count), 32'h0);
    bus.req = '0;
    bus.duration[2] = 8'd9;
    step();
    chk("t3_done",  32'(bus.done),  32'h4);
    chk("t3_cntd",  32'(bus.count), 32'h0);
    step();
    chk_idle("t3_end");

    // Duration 255: counts to all-ones without wrap; 257 cycles ack..done.
    bus.duration[3] = 8'd255;
    bus.req = 4'b1000;
    step();
    chk("t4_ack", 32'(bus.ack), 32'h8);
    bus.req = '0;
    for (int k = 1; k <= 255; k++) begin
      step();
      chk("t4_cnt", 32'(bus.count), 32'(k));
    end
    chk("t4_nodone", 32'(bus.done), 32'h0);
    step();
    chk("t4_done",  32'(bus.done),  32'h8);
    chk("t4_cntd",  32'(bus.count), 32'h0);
    step();
    chk_idle("t4_end");

    // Reset mid-RUN at count 5: outputs clear at once, no done, pointer back to 0.
    bus.duration[1] = 8'd10;
    bus.req = 4'b0010;
    step();
    chk("t5_ack", 32'(bus.ack), 32'h2);
    bus.req = '0;
    repeat (5) step();
    chk("t5_cnt5", 32'(bus.count), 32'h5);
    #2;
    reset_n = 1'b0;
    #1;
    chk_idle("t5_async");
    chk("t5_owner", 32'(bus.owner), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.done != '0) seen_done = 1'b1;
    end
    chk("t5_nodone", 32'(seen_done), 32'h0);
    bus.duration[0] = 8'd2;
    bus.req = 4'b1001;
    step();
    chk("t5_regrant", 32'(bus.ack),   32'h1);
    chk("t5_rgowner", 32'(bus.owner), 32'h0);
    bus.req = '0;
    repeat (3) step();
    chk("t5_rgdone", 32'(bus.done), 32'h1);
    step();

`ifdef TIMER_ARB_ABORT_EN
    // Abort coinciding with count == max: back to IDLE, no done, pointer advanced.
    bus.duration[0] = 8'd4;
    bus.req = 4'b0001;
    step();
    chk("t6_ack", 32'(bus.ack), 32'h1);
    bus.req = '0;
    repeat (4) step();
    chk("t6_cnt4", 32'(bus.count), 32'h4);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk_idle("t6_abort");
    step();
    chk("t6_nodone", 32'(bus.done), 32'h0);
    bus.duration[1] = 8'd1;
    bus.req = 4'b0011;
    step();
    chk("t6_next",   32'(bus.ack),   32'h2);
    chk("t6_nowner", 32'(bus.owner), 32'h1);
    bus.req = '0;
    repeat (3) step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
